uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//  Receive path for the UART echo design: samples the asynchronous rx pin, recovers
//  8N1 frames (1 start, 8 data LSB first, 1 stop) and delivers each byte to the echo
//  buffer over a valid/ready handshake. Flags framing errors and buffer overruns.
//  Sits between the board rx pin and the echo buffer; one clock domain.
// PARAMETERS
//  FCLK    100000000  system clock frequency in Hz
//  BAUD    115200     line rate in bit/s
//  CPB     FCLK/BAUD  (localparam, integer division) clocks per bit; 868 at defaults
//  HALF    CPB/2      (localparam) clocks from start edge to start-bit centre; 434
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  synchronous reset, active low
//  rx         in   1  asynchronous serial input, idle high
//  data_o     out  8  received byte, stable while valid_o=1
//  valid_o    out  1  data_o holds an unconsumed byte
//  ready_i    in   1  consumer accepts data_o when valid_o & ready_i
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  overrun    out  1  one-cycle pulse: completed byte dropped, holding register full
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, counters=0, sync FFs=1, data_o=0x00,
//   valid_o=0, frame_err=0, overrun=0. Reset mid-frame aborts it; partial byte discarded.
//  rx passes a 2-FF synchronizer (rx_s); all decisions use rx_s (2-cycle pin delay).
//  cnt counts clocks within a state; reset to 0 on every state transition and bit sample.
//  FSM:
//   IDLE   : rx_s=0 -> START (edge E0).
//   START  : at cnt=HALF-1 sample rx_s: 0 -> DATA; 1 -> IDLE (glitch, no flag).
//   DATA   : at cnt=CPB-1 shift rx_s into shreg bit[idx], idx 0..7 (LSB first);
//            after idx=7 -> STOP.
//   STOP   : at cnt=CPB-1 sample rx_s: 1 -> deliver byte, -> IDLE;
//            0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK  : wait for rx_s=1 -> IDLE (a held-low line never yields further frames).
//  Latency: delivery edge = E0 + HALF + 9*CPB; valid_o is 1 after that edge.
//  Holding register (1 entry):
//   - deliver & (!valid_o | ready_i): data_o<=shreg, valid_o<=1 (simultaneous
//     consume+deliver is lossless, no overrun).
//   - deliver & valid_o & !ready_i: overrun pulse, new byte dropped, data_o unchanged.
//   - no deliver & valid_o & ready_i: valid_o<=0 next edge.
//   - data_o changes only on a load; valid_o never drops without ready_i.
//  Flags are exactly one cycle wide and never asserted together.
//  Back-to-back frames: IDLE accepts a new start edge the cycle after STOP returns.
// TESTING (bench params FCLK=1000000, BAUD=100000 -> CPB=10, HALF=5; ready_i=1 unless noted)
//  1 rx frame 0x55 then idle -> valid_o 1 cycle at edge E0+95, data_o=0x55, no flags.
//  2 rx 0xA3 then 0x0F back-to-back, ready_i=0 until 300 cycles later -> data_o=0xA3
//    held, overrun pulse at second delivery, after ready_i: valid_o drops, no 0x0F.
//  3 rx low for 3 cycles then high -> START aborts to IDLE, valid_o=0, no flags.
//  4 frame 0xC3 with stop bit low, line held low 50 more cycles, then frame 0x81
//    -> one frame_err pulse, nothing delivered for 0xC3, 0x81 delivered correctly.
//  5 ready_i asserted on the delivery edge of 2nd byte while 1st pending -> 1st
//    consumed, data_o=2nd byte, valid_o stays 1, overrun=0.
//  6 rst_n=0 for 1 cycle mid DATA of 0x3C, then clean 0x7E -> only 0x7E delivered.

Source files
------------

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART receiver with a one-entry valid/ready holding register.
// The rx pin is synchronised, frames are recovered with a centre-sampling FSM,
// and completed bytes are offered to the echo buffer. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx_framer #(
    parameter int FCLK = 100000000,
    parameter int BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB  = FCLK / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic          sync1;
    logic          rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          deliver;
    logic          ferr;

    // Two-flop synchroniser for the asynchronous pin; idles high out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // Frame FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic: timer runs within a state and clears on every
    // transition or bit sample so each sample lands at a bit centre
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_n   = '0;
                    // a start bit that is gone by its centre was a glitch
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CW'(CPB - 1)) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CW'(CPB - 1)) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                // hold off until the line returns high so a stuck-low
                // line cannot manufacture further frames
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Holding register: load when empty or being drained this cycle,
    // otherwise drop the new byte and flag an overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= deliver & valid_o & ~ready_i;
            if (deliver && (!valid_o || ready_i)) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: drives 8N1 frames on the pin and compares the
// DUT every cycle against an event-driven reference of the holding register.
module tb_uart_rx_framer;

    localparam int FCLK = 1000000;
    localparam int BAUD = 100000;
    localparam int CPB  = FCLK / BAUD;
    localparam int HALF = CPB / 2;
    // pin change after edge N -> start accepted at edge N+3 (2 sync flops + IDLE)
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err;
    logic       overrun;

    uart_rx_framer #(.FCLK(FCLK), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference: each frame becomes an event at its predicted stop-sample edge
    typedef struct {
        int         cyc;
        logic [7:0] b;
        bit         err;
    } ev_t;
    ev_t evq[$];

    logic [7:0] m_data;
    bit         m_valid, m_fe, m_ov;
    bit         mon_en = 0;
    bit         prev_valid = 0;
    int         fe_cnt = 0, ov_cnt = 0, last_rise = -1;

    // Advance the reference at every edge using the inputs seen at that edge
    always @(posedge clk) begin : model
        ev_t ev;
        bit  dlv;
        cyc++;
        dlv = 0;
        if (!rst_n) begin
            m_data  = 8'h00;
            m_valid = 0;
            m_fe    = 0;
            m_ov    = 0;
            mon_en  = 1;
        end else begin
            m_fe = 0;
            m_ov = 0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.err) m_fe = 1;
                else        dlv  = 1;
            end
            if (dlv) begin
                if (!m_valid || ready_i) begin
                    m_data  = ev.b;
                    m_valid = 1;
                end else begin
                    m_ov = 1;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 0;
            end
        end
    end

    // Compare all outputs mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_o", 32'(valid_o), 32'(m_valid));
            chk("data_o", 32'(data_o), 32'(m_data));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("overrun", 32'(overrun), 32'(m_ov));
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (valid_o && !prev_valid) last_rise = cyc;
            prev_valid = valid_o;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; caller is #1 after an edge. Returns the edge index
    // after which the start bit appeared on the pin.
    task automatic send(input logic [7:0] b, input bit stop, input bit track, output int n);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        n = cyc;
        if (track) evq.push_back('{n + LAT, b, !stop});
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            wait_cyc(CPB);
        end
    endtask

    int  n, n1, fe0, ov0;
    bit  rnd_done;
    logic [7:0] rb;
    bit  rstop;
    logic [7:0] partial;

    initial begin
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);

        // 1: single frame, exact delivery edge
        send(8'h55, 1'b1, 1'b1, n);
        wait_cyc(20);
        chk("t1_rise_cycle", 32'(last_rise), 32'(n + LAT));
        chk("t1_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);

        // 2: back-to-back frames into a stalled consumer
        ov0 = ov_cnt;
        ready_i = 1'b0;
        send(8'hA3, 1'b1, 1'b1, n1);
        send(8'h0F, 1'b1, 1'b1, n);
        wait_cyc(n1 + 300 - cyc);
        chk("t2_held_data", 32'(data_o), 32'h0A3);
        chk("t2_held_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        wait_cyc(5);
        chk("t2_overruns", 32'(ov_cnt - ov0), 32'd1);
        chk("t2_drained", 32'(valid_o), 32'd0);

        // 3: short low glitch is rejected silently
        fe0 = fe_cnt;
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(30);
        chk("t3_valid", 32'(valid_o), 32'd0);
        chk("t3_no_ferr", 32'(fe_cnt - fe0), 32'd0);

        // 4: bad stop bit with line held low, then a clean frame
        fe0 = fe_cnt;
        send(8'hC3, 1'b0, 1'b1, n);
        wait_cyc(50);
        rx = 1'b1;
        wait_cyc(10);
        send(8'h81, 1'b1, 1'b1, n);
        wait_cyc(10);
        chk("t4_ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("t4_data", 32'(data_o), 32'h081);

        // 5: consume on the very edge the second byte lands
        ov0 = ov_cnt;
        ready_i = 1'b0;
        n1 = cyc;
        fork
            begin
                send(8'h11, 1'b1, 1'b1, n);
                send(8'hEE, 1'b1, 1'b1, n);
            end
            begin
                wait_cyc(10 * CPB + LAT - 1);
                ready_i = 1'b1;
                wait_cyc(1);
                chk("t5_data", 32'(data_o), 32'h0EE);
                chk("t5_valid", 32'(valid_o), 32'd1);
                chk("t5_overrun", 32'(overrun), 32'd0);
            end
        join
        wait_cyc(5);
        chk("t5_no_overrun", 32'(ov_cnt - ov0), 32'd0);

        // randomized frames, occasional bad stop bits, random backpressure
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    rb    = 8'($urandom);
                    rstop = ($urandom_range(0, 4) != 0);
                    send(rb, rstop, 1'b1, n);
                    rx = 1'b1;
                    wait_cyc(rstop ? $urandom_range(0, 15) : $urandom_range(5, 15));
                end
                wait_cyc(10);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    ready_i = 1'($urandom_range(0, 1));
                    wait_cyc(1);
                end
            end
        join
        ready_i = 1'b1;
        wait_cyc(5);
        chk("rnd_queue_empty", 32'(evq.size()), 32'd0);

        // 6: reset in the middle of a frame, then a clean frame
        partial = 8'h3C;
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            wait_cyc(CPB);
        end
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        rx = 1'b1;
        wait_cyc(1);
        chk("t6_reset_valid", 32'(valid_o), 32'd0);
        chk("t6_reset_data", 32'(data_o), 32'd0);
        wait_cyc(30);
        send(8'h7E, 1'b1, 1'b1, n);
        wait_cyc(20);
        chk("t6_rise_cycle", 32'(last_rise), 32'(n + LAT));
        chk("t6_data", 32'(data_o), 32'h07E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
